snn_delay_layer_cfg: RTL
========================

Name: snn_delay_layer_cfg

Overview:
- Parametrised leaky-integrate-and-fire layer: N_IN input spike channels fully connected to N_OUT neurons.
- Each synapse has its own signed weight and a programmable axonal delay of 0..2^DBITS-1 time steps.
- Weights and delays are loaded over a byte-wide valid/ready configuration stream instead of being tied to pins, which lets a pin-limited top level program every synapse independently.
- The block is the next-generation layer primitive used by the SNN top wrappers.

Parameters:
- N_IN, 8, input spike channels.
- N_OUT, 2, neurons.
- WBITS, 2, signed two's-complement weight width.
- DBITS, 2, delay field width; maximum delay MAXD = 2^DBITS-1 steps.
- VBITS, 6, signed membrane potential width.
- RBITS, 2, refractory counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cfg_start  in  1  pulse; restarts configuration load and clears dynamic state
- cfg_valid  in  1  cfg_data valid
- cfg_data  in  8  configuration byte
- cfg_ready  out  1  block accepts configuration bytes
- cfg_done  out  1  high while configured (RUN state)
- step  in  1  time-step strobe
- in_spikes  in  N_IN  input spikes, sampled when step=1
- threshold  in  VBITS-1  unsigned firing threshold
- decay  in  VBITS-1  unsigned leak per step
- refractory_period  in  RBITS  steps held silent after a spike
- out_spikes  out  N_OUT  registered spikes of the last step
- out_valid  out  1  one-cycle pulse after each processed step
- membrane_out  out  N_OUT*VBITS  signed potentials, neuron o at [o*VBITS +: VBITS]

Behaviour:

Reset and clocking:
- One clock. Reset is asynchronous and active-low (rst_n).
- In reset: state=CFG, byte counter=0, all potentials/history/refractory counters=0, out_spikes=0, out_valid=0, cfg_done=0, cfg_ready=1.

Configuration image:
- CFG_BITS = N_IN*N_OUT*(WBITS+DBITS); CFG_BYTES = ceil(CFG_BITS/8).
- Synapse s = o*N_IN+i occupies image bits [s*(WBITS+DBITS) +: WBITS+DBITS] = {delay, weight}.
- Byte k supplies image bits [8k+7:8k]. Unused bits of the last byte are ignored.

FSM:
- CFG state:
  - cfg_ready=1; step is ignored.
  - A byte is accepted on cfg_valid&cfg_ready.
  - Accepting byte CFG_BYTES-1 moves to RUN on the next edge; cfg_done=1 from that edge.
- RUN state:
  - cfg_ready=0; cfg_valid is ignored.
- cfg_start in any state:
  - Goes to CFG with counter=0 and clears potentials, history, refractory counters, out_spikes and cfg_done.
  - The config image is retained until overwritten.
  - cfg_start wins over a simultaneous cfg_valid (byte discarded) and over step (step dropped).

Delay lines:
- Per input, a MAXD-deep history shifts on each RUN step: hist[i][0] <= in_spikes[i], hist[i][k] <= hist[i][k-1].
- The delayed spike for synapse (i,o) with delay d is in_spikes[i] if d=0, else hist[i][d-1]. The value is taken before the shift.
- Net effect: a spike presented at step t with delay d contributes at step t+d.

Neuron update (on step in RUN; all registered on the same edge):
- Refractory case: if refr[o]>0, then refr[o] decrements, V[o]=0, and no spike is produced.
- Leak: otherwise V>0 gives max(V-decay,0); V<0 gives min(V+decay,0); V=0 stays 0.
- Integration: sum = sum over i of delayed(i,o)*w(i,o), computed at full width. V_new = saturate(V_leak+sum) to [-2^(VBITS-1), 2^(VBITS-1)-1].
- Firing: if V_new >= threshold (signed compare against the zero-extended threshold), then out_spikes[o]=1, V=0, refr[o]=refractory_period. Otherwise out_spikes[o]=0 and V=V_new.
- refractory_period=0 makes the neuron eligible on the very next step.

Output timing:
- out_valid pulses exactly one cycle, on the edge that processes step (latency 1 clock).
- out_spikes and membrane_out hold their values until the next processed step.
- Back-to-back steps on consecutive cycles are each processed.

Test Plan:
(All with defaults N_IN=8, N_OUT=2; CFG_BYTES=8.)
1. Load 8x0x11 (w=+1, d=0); threshold=3, decay=0, refr=0; step with in_spikes=0x07 -> out_valid next cycle, out_spikes=2'b11, membrane_out=0.
2. Load 8x0x99 (w=+1, d=2); threshold=1; steps with in_spikes=0x01,0,0,0 -> out_spikes=0,0,2'b11,0.
3. Config 0x11 bytes, refr=2, threshold=1, in_spikes=0x01 every step -> spikes at steps 1,4,7; V=0 during steps 2,3.
4. Load 8x0x22 (w=-2); in_spikes=0xFF for 3 steps -> V=-16, then -32, then -32 (saturated; membrane_out per neuron 0x20); no spikes.
5. Load 0x11 config, threshold=5, decay=1, in_spikes=0x03 then 0 -> V=2, then 1, then 0.
6. Send 3 bytes, pulse rst_n low mid-load -> cfg_done=0, counter=0; 8 more bytes needed before cfg_done=1. In RUN, assert cfg_start together with step -> step dropped, potentials=0, cfg_ready=1.

Source files
------------

// File: rtl/snn_delay_layer_cfg.sv
// snn_delay_layer_cfg
// Leaky-integrate-and-fire layer: N_IN spike inputs fully connected to N_OUT
// neurons. Every synapse has a signed weight and an axonal delay of
// 0..2^DBITS-1 steps. Weights and delays come in over a byte-wide valid/ready
// configuration stream and are kept in an internal image register.
module snn_delay_layer_cfg #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 2,
  parameter int WBITS = 2,
  parameter int DBITS = 2,
  parameter int VBITS = 6,
  parameter int RBITS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_valid,
  input  logic [7:0]               cfg_data,
  output logic                     cfg_ready,
  output logic                     cfg_done,
  input  logic                     step,
  input  logic [N_IN-1:0]          in_spikes,
  input  logic [VBITS-2:0]         threshold,
  input  logic [VBITS-2:0]         decay,
  input  logic [RBITS-1:0]         refractory_period,
  output logic [N_OUT-1:0]         out_spikes,
  output logic                     out_valid,
  output logic [N_OUT*VBITS-1:0]   membrane_out
);

  localparam int SYN_W     = WBITS + DBITS;
  localparam int N_SYN     = N_IN * N_OUT;
  localparam int CFG_BITS  = N_SYN * SYN_W;
  localparam int CFG_BYTES = (CFG_BITS + 7) / 8;
  localparam int MAXD      = (1 << DBITS) - 1;
  localparam int CNT_W     = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  // Full-width synaptic sum: N_IN terms of up to 2^(WBITS-1) magnitude each.
  localparam int SUM_W     = WBITS + $clog2(N_IN + 1) + 1;
  localparam int ACC_W     = ((VBITS > SUM_W) ? VBITS : SUM_W) + 1;

  typedef enum logic {
    ST_CFG = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q;
  logic [CFG_BYTES-1:0][7:0]       img_q;
  logic [CFG_BYTES*8-1:0]          img;
  logic [MAXD-1:0]                 hist_q [N_IN];
  logic [MAXD:0]                   tap    [N_IN];
  logic signed [WBITS-1:0]         w_syn  [N_SYN];
  logic [DBITS-1:0]                d_syn  [N_SYN];
  logic [N_SYN-1:0]                del_syn;
  logic                            accept;
  logic                            last_byte;
  logic                            step_run;
  logic                            out_valid_q;

  // A byte is taken only in CFG and only when no restart is requested.
  assign last_byte = (cnt_q == CNT_W'(CFG_BYTES - 1));
  assign accept    = (state_q == ST_CFG) && cfg_valid && !cfg_start;
  // A step is processed only in RUN; a restart on the same edge drops it.
  assign step_run  = (state_q == ST_RUN) && step && !cfg_start;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CFG;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (cfg_start)                state_d = ST_CFG;
    else if (accept && last_byte) state_d = ST_RUN;
  end

  // FSM outputs
  always_comb begin
    cfg_ready = (state_q == ST_CFG);
    cfg_done  = (state_q == ST_RUN);
  end

  // Byte counter: position of the next byte within the configuration image
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_q <= '0;
    else if (cfg_start) cnt_q <= '0;
    else if (accept)    cnt_q <= last_byte ? '0 : cnt_q + CNT_W'(1);
  end

  // Configuration image: not reset, survives restarts until overwritten
  always_ff @(posedge clk) begin
    if (accept) img_q[cnt_q] <= cfg_data;
  end

  assign img = img_q;

  // Per-input delay lines, shifted once per processed step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) hist_q[i] <= '0;
    end else if (cfg_start) begin
      for (int i = 0; i < N_IN; i++) hist_q[i] <= '0;
    end else if (step_run) begin
      for (int i = 0; i < N_IN; i++) hist_q[i] <= (hist_q[i] << 1) | MAXD'(in_spikes[i]);
    end
  end

  // Tap k of an input is the spike seen k steps ago (tap 0 = current input).
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_tap
    assign tap[gi] = {hist_q[gi], in_spikes[gi]};
  end

  // Unpack synapse fields and select each synapse's delayed spike
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_syn_o
    for (genvar gj = 0; gj < N_IN; gj++) begin : g_syn_i
      localparam int S = gi * N_IN + gj;
      assign w_syn[S]   = img[S*SYN_W +: WBITS];
      assign d_syn[S]   = img[S*SYN_W + WBITS +: DBITS];
      assign del_syn[S] = tap[gj][d_syn[S]];
    end
  end

  // Step-processed strobe, one cycle after the accepted step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid_q <= 1'b0;
    else        out_valid_q <= step_run;
  end

  assign out_valid = out_valid_q;

  // Neuron datapath: leak, integrate, saturate, fire, refractory hold
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
    logic signed [VBITS-1:0] v_q, v_d;
    logic [RBITS-1:0]        refr_q, refr_d;
    logic                    spk_q, spk_d;
    logic signed [SUM_W-1:0] sum;
    logic signed [VBITS:0]   v_ext, dec_ext, lk;
    logic signed [VBITS-1:0] v_leak, v_new, thr_s;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-VBITS:0]    acc_top;
    logic                    fire;

    // Weighted sum of this neuron's delayed spikes, at full width
    always_comb begin
      sum = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (del_syn[gi*N_IN+i]) begin
          sum = sum + {{(SUM_W-WBITS){w_syn[gi*N_IN+i][WBITS-1]}}, w_syn[gi*N_IN+i]};
        end
      end
    end

    // Leak toward zero by decay without crossing zero
    always_comb begin
      v_ext   = {v_q[VBITS-1], v_q};
      dec_ext = {2'b00, decay};
      lk      = '0;
      v_leak  = '0;
      if (v_q > 0) begin
        lk     = v_ext - dec_ext;
        v_leak = (lk < 0) ? '0 : lk[VBITS-1:0];
      end else if (v_q < 0) begin
        lk     = v_ext + dec_ext;
        v_leak = (lk > 0) ? '0 : lk[VBITS-1:0];
      end
    end

    // Integrate with saturation to the signed VBITS range, then compare
    always_comb begin
      acc     = {{(ACC_W-VBITS){v_leak[VBITS-1]}}, v_leak}
              + {{(ACC_W-SUM_W){sum[SUM_W-1]}}, sum};
      acc_top = acc[ACC_W-1:VBITS-1];
      if ((&acc_top) || !(|acc_top)) v_new = acc[VBITS-1:0];
      else if (acc[ACC_W-1])         v_new = {1'b1, {(VBITS-1){1'b0}}};
      else                           v_new = {1'b0, {(VBITS-1){1'b1}}};
      thr_s = {1'b0, threshold};
      fire  = (v_new >= thr_s);
    end

    // Next-state selection for potential, spike and refractory counter
    always_comb begin
      v_d    = v_q;
      refr_d = refr_q;
      spk_d  = spk_q;
      if (cfg_start) begin
        v_d    = '0;
        refr_d = '0;
        spk_d  = 1'b0;
      end else if (step_run) begin
        if (refr_q != '0) begin
          refr_d = refr_q - RBITS'(1);
          v_d    = '0;
          spk_d  = 1'b0;
        end else if (fire) begin
          v_d    = '0;
          refr_d = refractory_period;
          spk_d  = 1'b1;
        end else begin
          v_d    = v_new;
          spk_d  = 1'b0;
        end
      end
    end

    // Neuron state registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= '0;
        refr_q <= '0;
        spk_q  <= 1'b0;
      end else begin
        v_q    <= v_d;
        refr_q <= refr_d;
        spk_q  <= spk_d;
      end
    end

    assign out_spikes[gi]                = spk_q;
    assign membrane_out[gi*VBITS +: VBITS] = v_q;
  end

endmodule
